i2c_slave_passcode: RTL
=======================

# i2c_slave_passcode

I2C write-target that answers the passcode master on the board-level I2C bus. It oversamples SCL/SDA on a system clock, decodes device/register/data phases, and maintains an 8-entry register file. It checks passcode writes "PHSGNX" and gates OTP command writes behind the resulting unlock flag. It sits between the I2C pins and the OTP controller.

## Interface
- DEV_ADDR, 7'h0A, 7-bit device address matched on the bus
- NUM_REGS, 8, register count; valid register addresses are 0x00..NUM_REGS-1
- PASS_REG, 8'h05, passcode port register
- CMD_REG, 8'h04, OTP command register; writable only when unlocked
- clk  in  1  system clock, ≥ 8× SCL frequency; all logic is on its rising edge
- rst  in  1  asynchronous, active-high reset
- i2c_scl  in  1  bus SCL, asynchronous to clk
- i2c_sda  in  1  bus SDA, asynchronous to clk
- i2c_sda_oe  out  1  1 = pull SDA low (ACK/read-0); reset 0
- reg_wr_en  out  1  one-clk write strobe; reset 0
- reg_wr_addr  out  8  write address; reset 0x00
- reg_wr_data  out  8  write data; reset 0x00
- otp_cmd  out  8  contents of CMD_REG; reset 0x00
- unlock  out  1  passcode accepted; sticky; reset 0
- busy  out  1  high from START until STOP or IGNORE exit; reset 0

## Operation
- SCL and SDA each pass through a 2-flop synchronizer, then a previous-value register for edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are detected in any state.
- Bits are sampled on a SCL rising edge, MSB first. i2c_sda_oe changes only on a SCL falling edge.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, IGNORE. RD_DATA and RD_ACK exist only with the macro defined.
- IDLE → DEV_ADDR on START.
- DEV_ADDR shifts 8 bits (7 address bits plus R/W).
  - Address match with R/W=0 → DEV_ACK (ACK), then REG_ADDR.
  - Address mismatch → no ACK, go to IGNORE.
- REG_ADDR shifts 8 bits.
  - Address < NUM_REGS → REG_ACK (ACK); load the pointer.
  - Otherwise → NACK, go to IGNORE.
- WR_DATA shifts 8 bits → WR_ACK.
  - Always ACK, and pulse reg_wr_en with the pointer and data, except for a CMD_REG write while locked (ACK given, no strobe, otp_cmd unchanged).
  - After the byte, the pointer increments and wraps modulo NUM_REGS. At PASS_REG the pointer does not increment.
  - Return to WR_DATA for the next byte.
- Passcode check: a 3-bit index persists across transactions. Each byte written to PASS_REG is compared with char[index] (P=0x50, H=0x48, S=0x53, G=0x47, N=0x4E, X=0x58).
  - Match → index+1. At index 6, unlock=1 and the index holds.
  - Mismatch → index = (byte==0x50) ? 1 : 0.
  - Once unlocked, further PASS_REG writes are ignored by the checker.
- IGNORE: i2c_sda_oe=0; leave only on STOP (→ IDLE) or START (→ DEV_ADDR).
- Repeated START in any state → DEV_ADDR; the partial byte is discarded.
- STOP in any state → IDLE; the partial byte is discarded and no strobe is issued.
- Reset mid-transfer: all outputs, the pointer, the passcode index, and register contents return to reset values immediately.

## Timing
- Latency from pin edge to internal edge detect is 3 clk.
- i2c_sda_oe rises 1 clk after the detected SCL falling edge that ends bit 8. It falls 1 clk after the next detected SCL falling edge.
- reg_wr_en is asserted in the same clk that i2c_sda_oe rises for WR_ACK, for exactly 1 clk.
- reg_wr_addr and reg_wr_data are valid in that clk and hold until the next strobe.
- otp_cmd updates 1 clk after its strobe. unlock rises 1 clk after the strobe carrying 'X'.
- busy rises 1 clk after the detected START and falls 1 clk after the detected STOP.

## Configuration
- I2C_SLAVE_READ_EN defined:
  - R/W=1 with an address match is ACKed and enters RD_DATA.
  - reg[pointer] is shifted out MSB first; i2c_sda_oe = ~bit, updated on each SCL fall.
  - PASS_REG always reads 0x00.
  - Master ACK → pointer increments, go to next RD_DATA. Master NACK → IGNORE.
- Undefined: R/W=1 is NACKed and goes to IGNORE; no read logic is present.

## Structure
- Package i2c_slave_pkg holds:
  - state enum
  - DEV_ADDR, PASS_REG, and CMD_REG defaults
  - 6-entry passcode character constant array
  - PASS_LEN = 6
- Sub-module i2c_bus_monitor: synchronizers, edge detect, and scl_rise/scl_fall/start/stop pulses.

## Test plan
- Write dev 0x0A, reg 0x05, data 0x50 → 3 ACKs; reg_wr_en with addr 0x05, data 0x50; unlock stays 0.
- Six transactions P,H,S,G,N,X to 0x05 → unlock=1, 1 clk after the sixth strobe.
- Write dev 0x0B → SDA not pulled at ACK; no strobe; busy until STOP.
- Write 0x04 ← 0xA5 while locked → ACK, otp_cmd=0x00. After unlock, the same write → otp_cmd=0xA5.
- Sequence P,H,Q,P,H,S,G,N,X → unlock only after the final X. Write reg 0x00 ← 0x11, 0x22 → strobes at 0x00 then 0x01.
- STOP after 4 data bits → no strobe, state IDLE. Assert rst mid-byte → all outputs at reset values, and the next full transaction works.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C passcode write-target.
// Optional read path is enabled by defining I2C_SLAVE_READ_EN.
`timescale 1ns/1ps
package i2c_slave_pkg;

  // Protocol FSM states; the read states only exist when reads are built in
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_IGNORE
`ifdef I2C_SLAVE_READ_EN
    ,
    ST_RD_DATA,
    ST_RD_ACK
`endif
  } i2c_state_e;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h0A;
  localparam logic [7:0] PASS_REG_DEF = 8'h05;
  localparam logic [7:0] CMD_REG_DEF  = 8'h04;

  localparam int PASS_LEN = 6;

  // "PHSGNX", entry 0 in the least significant byte
  localparam logic [PASS_LEN-1:0][7:0] PASSCODE =
    {8'h58, 8'h4E, 8'h47, 8'h53, 8'h48, 8'h50};

  // Expected passcode character for a given checker index (0 beyond the end)
  function automatic logic [7:0] pass_char(input logic [2:0] idx);
    pass_char = 8'h00;
    for (int i = 0; i < PASS_LEN; i++) begin
      if (idx == 3'(i)) pass_char = PASSCODE[i];
    end
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Oversamples SCL/SDA: 2-flop synchronizers, a previous-value stage and
// registered one-clk event pulses (pin edge to pulse is 3 clk).
`timescale 1ns/1ps
module i2c_bus_monitor (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic bus_start,
  output logic bus_stop,
  output logic sda_bit
);

  // Bit 0 carries SCL, bit 1 carries SDA through every stage
  logic [1:0] meta_q, meta_d;
  logic [1:0] sync_q, sync_d;
  logic [1:0] prev_q, prev_d;
  // {sda_bit, stop, start, scl_fall, scl_rise}
  logic [4:0] ev_q, ev_d;

  // Synchronizer chain and edge/condition decode
  always_comb begin
    meta_d  = {sda_in, scl_in};
    sync_d  = meta_q;
    prev_d  = sync_q;
    ev_d[0] = sync_q[0] & ~prev_q[0];
    ev_d[1] = ~sync_q[0] & prev_q[0];
    ev_d[2] = sync_q[0] & prev_q[0] & prev_q[1] & ~sync_q[1];
    ev_d[3] = sync_q[0] & prev_q[0] & ~prev_q[1] & sync_q[1];
    ev_d[4] = sync_q[1];
  end

  // Stage registers; the idle bus is high on both lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 2'b11;
      sync_q <= 2'b11;
      prev_q <= 2'b11;
      ev_q   <= 5'b10000;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      ev_q   <= ev_d;
    end
  end

  assign scl_rise  = ev_q[0];
  assign scl_fall  = ev_q[1];
  assign bus_start = ev_q[2];
  assign bus_stop  = ev_q[3];
  assign sda_bit   = ev_q[4];

endmodule

// File: rtl/i2c_slave_passcode.sv
// I2C write-target with an 8-entry register file, a "PHSGNX" passcode
// checker and an unlock gate on the OTP command register.
// Define I2C_SLAVE_READ_EN to build the register read path.
`timescale 1ns/1ps
module i2c_slave_passcode
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int         NUM_REGS = 8,
  parameter logic [7:0] PASS_REG = PASS_REG_DEF,
  parameter logic [7:0] CMD_REG  = CMD_REG_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_scl,
  input  logic       i2c_sda,
  output logic       i2c_sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic [7:0] otp_cmd,
  output logic       unlock,
  output logic       busy
);

  localparam int PW = $clog2(NUM_REGS);
  localparam logic [PW-1:0] CMD_IDX = PW'(CMD_REG);

  logic scl_rise, scl_fall, bus_start, bus_stop, sda_bit;

  i2c_bus_monitor u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (i2c_scl),
    .sda_in    (i2c_sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .bus_start (bus_start),
    .bus_stop  (bus_stop),
    .sda_bit   (sda_bit)
  );

  i2c_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic        oe_q, oe_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic [2:0]  pass_idx_q, pass_idx_d;
  logic        unlock_q, unlock_d;
  logic [7:0]  regs_q [NUM_REGS];
  logic [7:0]  regs_d [NUM_REGS];

  logic [7:0]    ptr_ext;
  logic [PW-1:0] ptr_inc;
  logic          byte_done;

  assign ptr_ext   = 8'(ptr_q);
  assign ptr_inc   = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + PW'(1);
  assign byte_done = scl_fall && (cnt_q == 4'd8);

`ifdef I2C_SLAVE_READ_EN
  logic       rd_q, rd_d;
  logic       mack_q, mack_d;
  logic [7:0] rd_cur, rd_nxt;
  // The passcode port never reveals what was written to it
  assign rd_cur = (ptr_ext == PASS_REG) ? 8'h00 : regs_q[ptr_q];
  assign rd_nxt = (8'(ptr_inc) == PASS_REG) ? 8'h00 : regs_q[ptr_inc];
`endif

  // Protocol FSM, register commit and passcode checker next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    oe_d       = oe_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    pass_idx_d = pass_idx_q;
    unlock_d   = unlock_q;
    regs_d     = regs_q;
`ifdef I2C_SLAVE_READ_EN
    rd_d       = rd_q;
    mack_d     = mack_q;
`endif

    // A strobe lands in the register file and the checker one clk later
    if (wr_en_q) begin
      regs_d[wr_addr_q[PW-1:0]] = wr_data_q;
      if (wr_addr_q == PASS_REG && !unlock_q) begin
        if (wr_data_q == pass_char(pass_idx_q)) begin
          pass_idx_d = pass_idx_q + 3'd1;
          if (pass_idx_q == 3'(PASS_LEN - 1)) unlock_d = 1'b1;
        end else begin
          pass_idx_d = (wr_data_q == pass_char(3'd0)) ? 3'd1 : 3'd0;
        end
      end
    end

    if (bus_start) begin
      state_d = ST_DEV_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b1;
    end else if (bus_stop) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            shift_d = {shift_q[6:0], sda_bit};
            cnt_d   = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d = 4'd0;
            if (state_q == ST_DEV_ADDR) begin
              if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                state_d = ST_DEV_ACK;
                oe_d    = 1'b1;
`ifdef I2C_SLAVE_READ_EN
                rd_d    = 1'b0;
              end else if (shift_q[7:1] == DEV_ADDR) begin
                state_d = ST_DEV_ACK;
                oe_d    = 1'b1;
                rd_d    = 1'b1;
`endif
              end else begin
                state_d = ST_IGNORE;
                oe_d    = 1'b0;
              end
            end else if (state_q == ST_REG_ADDR) begin
              if (shift_q < 8'(NUM_REGS)) begin
                state_d = ST_REG_ACK;
                oe_d    = 1'b1;
                ptr_d   = shift_q[PW-1:0];
              end else begin
                state_d = ST_IGNORE;
                oe_d    = 1'b0;
              end
            end else begin
              // Data byte: always ACK; locked command writes are dropped
              state_d = ST_WR_ACK;
              oe_d    = 1'b1;
              if (!(ptr_ext == CMD_REG && !unlock_q)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ptr_ext;
                wr_data_d = shift_q;
              end
              ptr_d = (ptr_ext == PASS_REG) ? ptr_q : ptr_inc;
            end
          end
        end
        ST_DEV_ACK: begin
          if (scl_fall) begin
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            state_d = ST_REG_ADDR;
`ifdef I2C_SLAVE_READ_EN
            if (rd_q) begin
              state_d = ST_RD_DATA;
              shift_d = rd_cur;
              oe_d    = ~rd_cur[7];
            end
`endif
          end
        end
        ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            state_d = ST_WR_DATA;
          end
        end
        ST_IGNORE: oe_d = 1'b0;
`ifdef I2C_SLAVE_READ_EN
        ST_RD_DATA: begin
          if (scl_rise && cnt_q < 4'd8) begin
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            state_d = ST_RD_ACK;
            oe_d    = 1'b0;
          end else if (scl_fall && cnt_q != 4'd0) begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            mack_d = ~sda_bit;
          end else if (scl_fall) begin
            cnt_d = 4'd0;
            if (mack_q) begin
              state_d = ST_RD_DATA;
              ptr_d   = ptr_inc;
              shift_d = rd_nxt;
              oe_d    = ~rd_nxt[7];
            end else begin
              state_d = ST_IGNORE;
              oe_d    = 1'b0;
            end
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // All state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      shift_q    <= 8'h00;
      ptr_q      <= '0;
      oe_q       <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      pass_idx_q <= 3'd0;
      unlock_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 8'h00;
`ifdef I2C_SLAVE_READ_EN
      rd_q       <= 1'b0;
      mack_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      oe_q       <= oe_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      pass_idx_q <= pass_idx_d;
      unlock_q   <= unlock_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
`ifdef I2C_SLAVE_READ_EN
      rd_q       <= rd_d;
      mack_q     <= mack_d;
`endif
    end
  end

  assign i2c_sda_oe  = oe_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign otp_cmd     = regs_q[CMD_IDX];
  assign unlock      = unlock_q;
  assign busy        = busy_q;

endmodule
